rectangle_enc_ctrl: RTL and testbench

//   Iterative RECTANGLE-80 encryption engine wrapped around one rectangleRound instance.
//   - rectangleRound is combinational: state/keys/rc in, res/r_keys/orc out.
//   - Accepts a 64-bit plaintext and 80-bit key through a valid/ready handshake.
//   - Runs one round per clock, applies final key whitening, and presents the ciphertext

---
 rtl/rectangle_enc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rectangle_enc_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rectangle_enc_ctrl.sv
// rectangle_enc_ctrl: iterative RECTANGLE-80 encryption engine, one round per clock,
// wrapped around a single combinational rectangleRound instance.
// Build option: define RECTANGLE_EARLY_READY_EN to let a new job load in the same cycle
// the finished ciphertext is handed off (DONE -> RUN without visiting IDLE).
// Bit layout: cipher row 0 sits in the most significant 16 bits of state/key, so the
// 64-bit round key is always keys[79:16] and key row 4 is keys[15:0].

module rectangleRound (
  input  logic [63:0] state,
  input  logic [79:0] keys,
  input  logic [4:0]  r,
  input  logic [4:0]  rc,
  output logic [63:0] res,
  output logic [79:0] r_keys,
  output logic [4:0]  orc
);

  localparam logic [3:0] SBOX [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                                       4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};

  // Round index is carried for debug visibility only; the cipher round does not depend on it.
  logic unused_r;
  assign unused_r = ^r;

  function automatic logic [15:0] rol16(input logic [15:0] x, input int unsigned n);
    logic [31:0] y;
    y = {x, x} << n;
    return y[31:16];
  endfunction

  logic [3:0][15:0] s_row;
  logic [3:0][15:0] t_row;
  logic [3:0]       s_nib;

  // Data path: AddRoundKey, SubColumn across all 16 columns, then ShiftRow.
  always_comb begin
    // NOTE: every variable gets a value before any branch or loop, so no latch is inferred.
    s_nib = '0;
    for (int i = 0; i < 4; i++) begin
      s_row[i] = state[63-16*i -: 16] ^ keys[79-16*i -: 16];
      t_row[i] = '0;
    end
    for (int j = 0; j < 16; j++) begin
      s_nib = SBOX[{s_row[3][j], s_row[2][j], s_row[1][j], s_row[0][j]}];
      for (int i = 0; i < 4; i++) t_row[i][j] = s_nib[i];
    end
    res = {t_row[0], rol16(t_row[1], 1), rol16(t_row[2], 12), rol16(t_row[3], 13)};
  end

  logic [4:0][15:0] k_row;
  logic [3:0]       k_nib;
  logic [15:0]      k_row0_next;

  // Key schedule: S-box on the four rightmost columns, one Feistel step, round-constant XOR.
  always_comb begin
    k_nib = '0;
    for (int i = 0; i < 5; i++) k_row[i] = keys[79-16*i -: 16];
    for (int j = 0; j < 4; j++) begin
      k_nib = SBOX[{k_row[3][j], k_row[2][j], k_row[1][j], k_row[0][j]}];
      for (int i = 0; i < 4; i++) k_row[i][j] = k_nib[i];
    end
    k_row0_next = rol16(k_row[0], 8) ^ k_row[1] ^ {11'd0, rc};
    r_keys = {k_row0_next, k_row[2], k_row[3], rol16(k_row[3], 12) ^ k_row[4], k_row[0]};
  end

  // Round-constant LFSR: shift left, feedback is rc[4] ^ rc[2].
  assign orc = {rc[3:0], rc[4] ^ rc[2]};

endmodule

module rectangle_enc_ctrl #(
  parameter int         ROUNDS  = 25,
  parameter logic [4:0] RC_INIT = 5'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pt,
  input  logic [79:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_ct,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

  fsm_t        fsm_q;
  logic [63:0] state_q;
  logic [79:0] key_q;
  logic [4:0]  rc_q;
  logic [4:0]  rnd_q;

  logic [63:0] res;
  logic [79:0] r_keys;
  logic [4:0]  orc;
  logic        accept;

  rectangleRound u_round (
    .state  (state_q),
    .keys   (key_q),
    .r      (rnd_q),
    .rc     (rc_q),
    .res    (res),
    .r_keys (r_keys),
    .orc    (orc)
  );

  // Ready is decoded from the registered FSM state; the early-ready build also follows out_ready in DONE.
`ifdef RECTANGLE_EARLY_READY_EN
  assign in_ready = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
`else
  assign in_ready = (fsm_q == IDLE);
`endif

  assign accept = in_valid && in_ready;
  assign busy   = (fsm_q != IDLE);

  // Control FSM and round registers; a load on acceptance overrides the per-state update.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are cleared too so a discarded job leaves no trace of its key.
      fsm_q     <= IDLE;
      state_q   <= '0;
      key_q     <= '0;
      rc_q      <= RC_INIT;
      rnd_q     <= '0;
      out_valid <= 1'b0;
      out_ct    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      case (fsm_q)
        IDLE: ;
        RUN: begin
          state_q <= res;
          key_q   <= r_keys;
          rc_q    <= orc;
          rnd_q   <= rnd_q + 5'd1;
          if (rnd_q == LAST_RND) begin
            out_ct    <= res ^ r_keys[79:16];
            out_valid <= 1'b1;
            fsm_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm_q     <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
      if (accept) begin
        state_q <= in_pt;
        key_q   <= in_key;
        rc_q    <= RC_INIT;
        rnd_q   <= '0;
        fsm_q   <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_rectangle_enc_ctrl.sv
// tb_rectangle_enc_ctrl: self-checking bench for rectangle_enc_ctrl with a behavioural
// RECTANGLE-80 model built from the cipher's row/column description.

module tb_rectangle_enc_ctrl;

  localparam int ROUNDS = 25;
  localparam logic [63:0] GOLD_ZERO = 64'h2D96E354E8B10874;
  localparam logic [63:0] GOLD_ONES = 64'h9945AA34AE3D0112;
`ifdef RECTANGLE_EARLY_READY_EN
  localparam int B2B_GAP = ROUNDS + 1;
`else
  localparam int B2B_GAP = ROUNDS + 2;
`endif

  localparam int SBOX_TAB [16] = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};
  localparam logic [4:0] RC_TAB [25] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B,
                                         5'h16, 5'h0C, 5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F,
                                         5'h1E, 5'h1C, 5'h18, 5'h11, 5'h03, 5'h06, 5'h0D,
                                         5'h1B, 5'h17, 5'h0E, 5'h1D};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pt;
  logic [79:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_ct;
  logic        busy;

  int total = 0;
  int bad   = 0;

  rectangle_enc_ctrl #(.ROUNDS(ROUNDS), .RC_INIT(5'h01)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural reference model ----------------
  function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
    int v;
    v = int'(x);
    return 16'(((v << n) | (v >> (16 - n))) & 32'hFFFF);
  endfunction

  function automatic logic [3:0][15:0] sub_cols(input logic [3:0][15:0] m, input int ncols);
    logic [3:0][15:0] o;
    int v;
    int s;
    o = m;
    for (int j = 0; j < ncols; j++) begin
      v = 8 * int'(m[3][j]) + 4 * int'(m[2][j]) + 2 * int'(m[1][j]) + int'(m[0][j]);
      s = SBOX_TAB[v];
      for (int i = 0; i < 4; i++) o[i][j] = 1'((s >> i) & 1);
    end
    return o;
  endfunction

  function automatic logic [63:0] model_encrypt(input logic [63:0] pt, input logic [79:0] key);
    logic [3:0][15:0] w;
    logic [4:0][15:0] k;
    logic [3:0][15:0] ks;
    logic [15:0]      row4;
    for (int i = 0; i < 4; i++) w[i] = pt[63-16*i -: 16];
    for (int i = 0; i < 5; i++) k[i] = key[79-16*i -: 16];
    for (int r = 0; r < ROUNDS; r++) begin
      for (int i = 0; i < 4; i++) w[i] = w[i] ^ k[i];
      w = sub_cols(w, 16);
      w[1] = rotl(w[1], 1);
      w[2] = rotl(w[2], 12);
      w[3] = rotl(w[3], 13);
      for (int i = 0; i < 4; i++) ks[i] = k[i];
      ks   = sub_cols(ks, 4);
      row4 = k[4];
      k[0] = rotl(ks[0], 8) ^ ks[1] ^ {11'd0, RC_TAB[r]};
      k[1] = ks[2];
      k[2] = ks[3];
      k[3] = rotl(ks[3], 12) ^ row4;
      k[4] = ks[0];
    end
    return {w[0] ^ k[0], w[1] ^ k[1], w[2] ^ k[2], w[3] ^ k[3]};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [79:0] rand80();
    return {$urandom(), $urandom(), 16'($urandom())};
  endfunction

  // ---------------- stimulus helpers ----------------
  // Offers one job, waits for acceptance, then waits for out_valid; lat counts edges after acceptance.
  task automatic do_job(input logic [63:0] pt, input logic [79:0] key, input bit noisy,
                        output logic [63:0] ct, output int lat, output bit ok);
    int guard;
    ok  = 1'b1;
    lat = 0;
    ct  = '0;
    @(negedge clk);
    in_valid = 1'b1;
    in_pt    = pt;
    in_key   = key;
    guard    = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      ok       = 1'b0;
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_pt    = rand64();
    in_key   = rand80();
    while (!out_valid && lat < 200) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        in_pt    = rand64();
        in_key   = rand80();
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) ok = 1'b0;
    ct = out_ct;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_pt     = '0;
    in_key    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++;
      $display("FAIL reset_flags: got valid/busy/ready=%b required 001", {out_valid, busy, in_ready});
    end
    total++;
    if (out_ct !== 64'h0) begin
      bad++;
      $display("FAIL reset_ct: got %h required %h", out_ct, 64'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_vector_zero();
    logic [63:0] ct;
    int          lat;
    bit          ok;
    do_job(64'h0, 80'h0, 1'b0, ct, lat, ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL zero_handshake: got ok=%0d required 1", ok);
    end
    total++;
    if (ct !== GOLD_ZERO) begin
      bad++;
      $display("FAIL zero_ct: got %h required %h", ct, GOLD_ZERO);
    end
    total++;
    if (lat !== ROUNDS) begin
      bad++;
      $display("FAIL zero_latency: got %0d required %0d", lat, ROUNDS);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] ct;
    int          lat;
    bit          ok;
    wait_idle();
    out_ready = 1'b0;
    do_job(64'hFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF, 1'b0, ct, lat, ok);
    total++;
    if (ok !== 1'b1 || ct !== GOLD_ONES) begin
      bad++;
      $display("FAIL ones_ct: got %h (ok=%0d) required %h", ct, ok, GOLD_ONES);
    end
    total++;
    if (lat !== ROUNDS) begin
      bad++;
      $display("FAIL ones_latency: got %0d required %0d", lat, ROUNDS);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, busy, out_ct} !== {1'b1, 1'b0, 1'b1, GOLD_ONES}) begin
        bad++;
        $display("FAIL hold_cycle%0d: got valid=%b ready=%b busy=%b ct=%h required 1 0 1 %h",
                 c, out_valid, in_ready, busy, out_ct, GOLD_ONES);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL release_idle: got valid/ready/busy=%b required 010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] ct;
    int          lat;
    bit          ok;
    bit          seen;
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1;
    in_pt    = rand64();
    in_key   = rand80();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL midreset_flags: got valid/ready/busy=%b required 010", {out_valid, in_ready, busy});
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL midreset_no_output: got out_valid seen=%0d required 0", seen);
    end
    do_job(64'h0, 80'h0, 1'b0, ct, lat, ok);
    total++;
    if (ok !== 1'b1 || ct !== GOLD_ZERO) begin
      bad++;
      $display("FAIL midreset_rerun: got %h (ok=%0d) required %h", ct, ok, GOLD_ZERO);
    end
  endtask

  task automatic test_ignore_inputs();
    logic [63:0] pt;
    logic [79:0] key;
    logic [63:0] ct;
    logic [63:0] exp_ct;
    int          lat;
    bit          ok;
    for (int n = 0; n < 3; n++) begin
      wait_idle();
      pt     = rand64();
      key    = rand80();
      exp_ct = model_encrypt(pt, key);
      do_job(pt, key, 1'b1, ct, lat, ok);
      total++;
      if (ok !== 1'b1 || ct !== exp_ct || lat !== ROUNDS) begin
        bad++;
        $display("FAIL noisy_job%0d: got ct=%h lat=%0d ok=%0d required ct=%h lat=%0d",
                 n, ct, lat, ok, exp_ct, ROUNDS);
      end
    end
  endtask

  task automatic test_random_jobs();
    logic [63:0] pt;
    logic [79:0] key;
    logic [63:0] ct;
    logic [63:0] exp_ct;
    int          lat;
    bit          ok;
    for (int n = 0; n < 6; n++) begin
      wait_idle();
      pt     = rand64();
      key    = rand80();
      exp_ct = model_encrypt(pt, key);
      do_job(pt, key, 1'b0, ct, lat, ok);
      total++;
      if (ok !== 1'b1 || ct !== exp_ct) begin
        bad++;
        $display("FAIL random_job%0d: got %h (ok=%0d) required %h", n, ct, ok, exp_ct);
      end
      total++;
      if (lat !== ROUNDS) begin
        bad++;
        $display("FAIL random_latency%0d: got %0d required %0d", n, lat, ROUNDS);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pts  [2];
    logic [79:0] keys [2];
    logic [63:0] got  [$];
    int          acc  [2];
    int          idx;
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      pts[i]  = rand64();
      keys[i] = rand80();
      acc[i]  = -1;
    end
    out_ready = 1'b1;
    idx       = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_pt    = pts[0];
    in_key   = keys[0];
    for (int n = 0; n < 300 && got.size() < 2; n++) begin
      if (out_valid && out_ready) got.push_back(out_ct);
      if (in_valid && in_ready && idx < 2) begin
        acc[idx] = n;
        idx++;
      end
      @(negedge clk);
      if (idx == 1) begin
        in_pt  = pts[1];
        in_key = keys[1];
      end else if (idx >= 2) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    total++;
    if (idx !== 2 || (acc[1] - acc[0]) !== B2B_GAP) begin
      bad++;
      $display("FAIL b2b_gap: got accepts=%0d gap=%0d required accepts=2 gap=%0d",
               idx, acc[1] - acc[0], B2B_GAP);
    end
    total++;
    if (got.size() !== 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d results required 2", got.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got[i] !== model_encrypt(pts[i], keys[i])) begin
          bad++;
          $display("FAIL b2b_ct%0d: got %h required %h", i, got[i], model_encrypt(pts[i], keys[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vector_zero();
    test_backpressure();
    test_mid_reset();
    test_ignore_inputs();
    test_random_jobs();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
